// File: rtl/mem_pkg.sv
// mem_pkg: shared types and width helpers for the main_mem backing store.
package mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_BURST = 2'd2,
    WR_WAIT  = 2'd3
  } state_e;

  // Index width for n entries, never below one bit so single-entry cases stay legal.
  function automatic int width_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: DEPTH_WORDS x 32 single-port word RAM, synchronous write,
// asynchronous read so the controller can register the beat data itself.
module mem_array
  import mem_pkg::*;
#(
  parameter int  DEPTH_WORDS = 1024,
  localparam int AW          = width_min1(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  // Word write on the shared port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/main_mem.sv
// main_mem: multi-cycle backing memory below the cache controller.
// Line fills come back as LINE_WORDS beats on MemReadReady; word writes are
// acknowledged by a single MemWriteDone pulse. Define MAIN_MEM_STATS_EN to add
// the RdCount/WrCount statistics counters and their StatClr input.
//
// state    | meaning
// IDLE     | sampling requests; read wins over a simultaneous write
// RD_WAIT  | read latency countdown
// RD_BURST | one beat per cycle, offsets 0..LINE_WORDS-1
// WR_WAIT  | write latency countdown, commit edge, then acknowledge cycle
module main_mem
  import mem_pkg::*;
#(
  parameter int  DEPTH_WORDS = 1024,
  parameter int  LINE_WORDS  = 4,
  parameter int  RD_LATENCY  = 8,
  parameter int  WR_LATENCY  = 6,
  localparam int OFF_W       = width_min1(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       MemAddr,
  input  logic [31:0]       MemWData,
  output logic [31:0]       MemRData,
  output logic [OFF_W-1:0]  FillIdx,
  output logic              MemReadReady,
  output logic              MemWriteDone,
`ifdef MAIN_MEM_STATS_EN
  input  logic              StatClr,
  output logic [31:0]       RdCount,
  output logic [31:0]       WrCount,
`endif
  output logic              MemBusy
);

  localparam int AW      = width_min1(DEPTH_WORDS);
  localparam int LAT_MAX = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CNT_W   = width_min1(LAT_MAX + 1);

  localparam logic [AW-1:0]    LINE_MASK = AW'(LINE_WORDS - 1);
  localparam logic [OFF_W-1:0] LAST_OFF  = OFF_W'(LINE_WORDS - 1);
  // Read counter hits zero on the edge that launches the first beat.
  localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);
  // Write counter reaches one on the commit edge, zero during the ack cycle.
  localparam logic [CNT_W-1:0] WR_LOAD   = CNT_W'(WR_LATENCY);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     base_q, base_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;

  logic [AW-1:0]     req_idx;
  logic [AW-1:0]     arr_addr;
  logic [WORD_W-1:0] arr_rdata;
  logic              arr_we;
  logic              unused_addr;

  assign req_idx     = MemAddr[2 +: AW];
  assign unused_addr = ^{MemAddr[31:2+AW], MemAddr[1:0]};

  // State register plus latched request fields and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      base_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      off_q     <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      off_q     <= off_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  // Next state: request acceptance, latency countdowns, beat sequencing.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    off_d     = off_q;
    case (state_q)
      IDLE: begin
        if (MemRead) begin
          base_d = req_idx & ~LINE_MASK;
          off_d  = '0;
          cnt_d  = RD_LOAD;
          state_d = (RD_LATENCY == 1) ? RD_BURST : RD_WAIT;
        end else if (MemWrite) begin
          wr_addr_d = req_idx;
          wr_data_d = MemWData;
          cnt_d     = WR_LOAD;
          state_d   = WR_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          off_d   = '0;
          state_d = RD_BURST;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RD_BURST: begin
        if (off_q == LAST_OFF) begin
          off_d   = '0;
          state_d = IDLE;
        end else begin
          off_d = off_q + OFF_W'(1);
        end
      end
      WR_WAIT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: array port steering and the values registered for the next cycle.
  always_comb begin
    arr_we   = !rst && (state_q == WR_WAIT) && (cnt_q == CNT_W'(1));
    arr_addr = arr_we ? wr_addr_q : (base_d + AW'(off_d));
    ready_d  = (state_d == RD_BURST);
    rdata_d  = ready_d ? arr_rdata : '0;
    done_d   = arr_we;
  end

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .addr (arr_addr),
    .wdata(wr_data_q),
    .rdata(arr_rdata)
  );

  assign MemRData     = rdata_q;
  assign FillIdx      = off_q;
  assign MemReadReady = ready_q;
  assign MemWriteDone = done_q;
  assign MemBusy      = (state_q != IDLE);

`ifdef MAIN_MEM_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  // Fill and commit counters; a clear beats a same-cycle increment.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (StatClr) begin
      rd_cnt_d = '0;
      wr_cnt_d = '0;
    end else begin
      if ((state_q == RD_BURST) && (off_q == LAST_OFF)) begin
        rd_cnt_d = rd_cnt_q + 32'd1;
      end
      if (arr_we) begin
        wr_cnt_d = wr_cnt_q + 32'd1;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign RdCount = rd_cnt_q;
  assign WrCount = wr_cnt_q;
`endif

endmodule

// File: tb/tb_main_mem.sv
// tb_main_mem: scoreboard bench for main_mem. dut0 uses the default
// parameters, dut1 uses RD_LATENCY=1 for the single-cycle and wrap cases.
module tb_main_mem;

  typedef struct {
    bit          is_beat;
    int          stamp;
    int          idx;
    logic [31:0] data;
  } ev_t;

  localparam int RL [2] = '{8, 1};
  localparam int WL     = 6;

  logic        clk;
  logic        rst     [2];
  logic        rd      [2];
  logic        wr      [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic [31:0] rdata   [2];
  logic [1:0]  fidx    [2];
  logic        rrdy    [2];
  logic        wdone   [2];
  logic        busy    [2];
`ifdef MAIN_MEM_STATS_EN
  logic        clr     [2];
  logic [31:0] rdcnt   [2];
  logic [31:0] wrcnt   [2];
`endif

  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  ev_t         sb [2][$];
  logic [31:0] model [2][1024];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  main_mem #(.DEPTH_WORDS(1024), .LINE_WORDS(4), .RD_LATENCY(8), .WR_LATENCY(6)) dut0 (
    .clk(clk), .rst(rst[0]), .MemRead(rd[0]), .MemWrite(wr[0]),
    .MemAddr(addr_s[0]), .MemWData(wdata_s[0]), .MemRData(rdata[0]),
    .FillIdx(fidx[0]), .MemReadReady(rrdy[0]), .MemWriteDone(wdone[0]),
`ifdef MAIN_MEM_STATS_EN
    .StatClr(clr[0]), .RdCount(rdcnt[0]), .WrCount(wrcnt[0]),
`endif
    .MemBusy(busy[0])
  );

  main_mem #(.DEPTH_WORDS(1024), .LINE_WORDS(4), .RD_LATENCY(1), .WR_LATENCY(6)) dut1 (
    .clk(clk), .rst(rst[1]), .MemRead(rd[1]), .MemWrite(wr[1]),
    .MemAddr(addr_s[1]), .MemWData(wdata_s[1]), .MemRData(rdata[1]),
    .FillIdx(fidx[1]), .MemReadReady(rrdy[1]), .MemWriteDone(wdone[1]),
`ifdef MAIN_MEM_STATS_EN
    .StatClr(clr[1]), .RdCount(rdcnt[1]), .WrCount(wrcnt[1]),
`endif
    .MemBusy(busy[1])
  );

  // Monitor: every strobe pops one expected event; an overdue event is a miss.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rrdy[d] || wdone[d]) begin
        vectors++;
        if (sb[d].size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_strobe_dut%0d: got rrdy=%b wdone=%b at cyc %0d, expected no strobe",
                   d, rrdy[d], wdone[d], cyc);
        end else begin
          ev_t e;
          e = sb[d].pop_front();
          if ((rrdy[d] !== e.is_beat) || (wdone[d] !== !e.is_beat) || (cyc != e.stamp) ||
              (e.is_beat && ((int'(fidx[d]) != e.idx) || (rdata[d] !== e.data)))) begin
            miscompares++;
            $display("FAIL sb_dut%0d: got rrdy=%b wdone=%b idx=%0d data=%h cyc=%0d, expected beat=%b idx=%0d data=%h cyc=%0d",
                     d, rrdy[d], wdone[d], fidx[d], rdata[d], cyc, e.is_beat, e.idx, e.data, e.stamp);
          end
        end
      end else if (sb[d].size() != 0 && sb[d][0].stamp < cyc) begin
        ev_t e;
        e = sb[d].pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missing_strobe_dut%0d: got nothing by cyc %0d, expected beat=%b idx=%0d at cyc %0d",
                 d, cyc, e.is_beat, e.idx, e.stamp);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of stimulus by %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string name, input int d);
    check(name, 64'({busy[d], wdone[d], rrdy[d], fidx[d], rdata[d]}), 64'd0);
  endtask

  // Issue a line fill at the current negedge; expected beats come from the model.
  task automatic do_read(input int d, input logic [31:0] addr);
    int a, base;
    base = int'((addr >> 2) & 32'h3FF) & ~3;
    rd[d] = 1'b1;
    addr_s[d] = addr;
    a = cyc + 1;
    for (int j = 0; j < 4; j++)
      sb[d].push_back(ev_t'{is_beat: 1'b1, stamp: a + RL[d] - 1 + j, idx: j, data: model[d][base + j]});
    while (cyc < a + RL[d] + 2) @(negedge clk);
    rd[d] = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_write(input int d, input logic [31:0] addr, input logic [31:0] data);
    int a;
    wr[d] = 1'b1;
    addr_s[d] = addr;
    wdata_s[d] = data;
    a = cyc + 1;
    sb[d].push_back(ev_t'{is_beat: 1'b0, stamp: a + WL, idx: 0, data: 32'd0});
    while (cyc < a + WL) @(negedge clk);
    wr[d] = 1'b0;
    model[d][int'((addr >> 2) & 32'h3FF)] = data;
    @(negedge clk);
  endtask

  initial begin
    int a;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0; addr_s[d] = '0; wdata_s[d] = '0;
`ifdef MAIN_MEM_STATS_EN
      clr[d] = 1'b0;
`endif
    end
    repeat (3) @(negedge clk);
    check_idle("reset_state_dut0", 0);
    check_idle("reset_state_dut1", 1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    check_idle("idle_after_reset_dut0", 0);

    for (int i = 0; i < 16; i++) begin
      do_write(0, 32'h100 + 32'(4 * i), 32'hA000_0040 + 32'(i));
      do_write(0, 32'(4 * i), 32'hB000_0000 + 32'(i));
    end

    do_read(0, 32'h0000_0108);
    do_write(0, 32'h0000_0020, 32'hDEAD_BEEF);
    do_read(0, 32'h0000_002C);

    // Read and write together: burst first, write taken in the following IDLE cycle.
    rd[0] = 1'b1; wr[0] = 1'b1; addr_s[0] = 32'h0000_0110; wdata_s[0] = 32'h5555_AAAA;
    a = cyc + 1;
    for (int j = 0; j < 4; j++)
      sb[0].push_back(ev_t'{is_beat: 1'b1, stamp: a + 7 + j, idx: j, data: model[0][32'h44 + j]});
    sb[0].push_back(ev_t'{is_beat: 1'b0, stamp: a + 12 + WL, idx: 0, data: 32'd0});
    while (cyc < a + 10) @(negedge clk);
    rd[0] = 1'b0;
    while (cyc < a + 12 + WL) @(negedge clk);
    wr[0] = 1'b0;
    model[0][32'h44] = 32'h5555_AAAA;
    @(negedge clk);
    do_read(0, 32'h0000_0110);

    // Reset during the second beat of a burst.
    rd[0] = 1'b1; addr_s[0] = 32'h0000_0100;
    a = cyc + 1;
    for (int j = 0; j < 2; j++)
      sb[0].push_back(ev_t'{is_beat: 1'b1, stamp: a + 7 + j, idx: j, data: model[0][32'h40 + j]});
    while (cyc < a + 8) @(negedge clk);
    rst[0] = 1'b1;
    rd[0] = 1'b0;
    @(negedge clk);
    check_idle("rst_mid_burst", 0);
    rst[0] = 1'b0;
    repeat (4) @(negedge clk);

    // Reset three cycles into a write: no ack, word keeps its old value.
    wr[0] = 1'b1; addr_s[0] = 32'h0000_0104; wdata_s[0] = 32'h1234_5678;
    a = cyc + 1;
    while (cyc < a + 2) @(negedge clk);
    rst[0] = 1'b1;
    wr[0] = 1'b0;
    @(negedge clk);
    check_idle("rst_mid_write", 0);
    rst[0] = 1'b0;
    repeat (8) @(negedge clk);
    do_read(0, 32'h0000_0100);

    do_read(0, 32'h0000_1004);

    for (int i = 0; i < 4; i++) do_write(1, 32'(4 * i), 32'hC000_0000 + 32'(i));
`ifdef MAIN_MEM_STATS_EN
    check("wrcount_before_clr", 64'(wrcnt[1]), 64'd4);
    clr[1] = 1'b1;
    @(negedge clk);
    clr[1] = 1'b0;
    check("wrcount_after_clr", 64'(wrcnt[1]), 64'd0);
`endif
    do_read(1, 32'h0000_1000);
`ifdef MAIN_MEM_STATS_EN
    check("rdcount_after_fill", 64'(rdcnt[1]), 64'd1);
    check("wrcount_after_fill", 64'(wrcnt[1]), 64'd0);
`endif

    repeat (20) @(negedge clk);
    check("sb_drained_dut0", 64'(sb[0].size()), 64'd0);
    check("sb_drained_dut1", 64'(sb[1].size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
